// File: rtl/fetch_arb_pkg.sv
// fetch_arb shared types: FSM state encoding, 17-bit FIFO entry
// layout (bit 16 = frm, bits 15:0 = data) and the frame-length helper.
package fetch_arb_pkg;

    localparam int DATA_W  = 16;
    localparam int ENTRY_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2
    } state_t;

    typedef struct packed {
        logic              frm;
        logic [DATA_W-1:0] data;
    } entry_t;

    // A zero length still means one word: the frame start itself.
    function automatic logic [DATA_W-1:0] eff_len(
        input logic [DATA_W-1:0] len
    );
        return (len == '0) ? 16'd1 : len;
    endfunction

endpackage

// File: rtl/fetch_arb_fifo.sv
// fetch_arb_fifo: per-channel word FIFO, depth 2**FIFO_AW, with flush.
// Ports: clk_sys, rst_n, flush, push/din, pop/dout, empty, drop.
module fetch_arb_fifo
    import fetch_arb_pkg::*;
#(
    parameter int FIFO_AW = 3
) (
    input  logic   clk_sys,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   push,
    input  entry_t din,
    input  logic   pop,
    output entry_t dout,
    output logic   empty,
    output logic   drop
);

    localparam logic [FIFO_AW:0] ONE = 1;

    logic [FIFO_AW:0] wptr;
    logic [FIFO_AW:0] rptr;
    logic             full;
    logic             wr_en;
    logic             rd_en;
    entry_t           mem [2**FIFO_AW];

    assign empty = (wptr == rptr);
    assign full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                   (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);

    // Fullness is judged before any same-cycle pop; flush wins over both.
    assign wr_en = push && !full && !flush;
    assign rd_en = pop && !empty && !flush;
    assign drop  = push && full && !flush;
    assign dout  = mem[rptr[FIFO_AW-1:0]];

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + ONE;
            if (rd_en) rptr <= rptr + ONE;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (wr_en) mem[wptr[FIFO_AW-1:0]] <= din;
    end

endmodule

// File: rtl/fetch_arb.sv
// fetch_arb: merges two framed package streams (A/B) into one, frame by frame.
// Ports: fire_sync, pkga_*/pkgb_* in, len_pkg, tout_cyc; pkg_* out, ovf_*, err_*, busy.
module fetch_arb
    import fetch_arb_pkg::*;
#(
    parameter int FIFO_AW = 3,
    parameter int TOUT_W  = 20
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              fire_sync,
    input  logic [15:0]       pkga_data,
    input  logic              pkga_vld,
    input  logic              pkga_frm,
    input  logic [15:0]       pkgb_data,
    input  logic              pkgb_vld,
    input  logic              pkgb_frm,
    input  logic [15:0]       len_pkg,
    input  logic [TOUT_W-1:0] tout_cyc,
    output logic [15:0]       pkg_data,
    output logic              pkg_vld,
    output logic              pkg_frm,
    output logic              pkg_src,
    output logic              ovf_a,
    output logic              ovf_b,
    output logic              err_trunc,
    output logic              err_tout,
    output logic              busy
);

    localparam logic [TOUT_W-1:0] T_ONE = 1;

    state_t            state;
    logic              last_b;
    logic [15:0]       len_q;
    logic [15:0]       cnt;
    logic [TOUT_W-1:0] tcnt;

    entry_t head_a, head_b, sel_head;
    logic   empty_a, empty_b, sel_empty;
    logic   drop_a, drop_b, pop_a, pop_b;
    logic   idle, granted, sel_b;
    logic   elig_a, elig_b, gnt_a, gnt_b;
    logic   g_pop, g_trunc, g_tout, fin;
    logic [15:0] len_eff;

    fetch_arb_fifo #(.FIFO_AW(FIFO_AW)) u_fifo_a (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .flush   (fire_sync),
        .push    (pkga_vld),
        .din     ({pkga_frm, pkga_data}),
        .pop     (pop_a),
        .dout    (head_a),
        .empty   (empty_a),
        .drop    (drop_a)
    );

    fetch_arb_fifo #(.FIFO_AW(FIFO_AW)) u_fifo_b (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .flush   (fire_sync),
        .push    (pkgb_vld),
        .din     ({pkgb_frm, pkgb_data}),
        .pop     (pop_b),
        .dout    (head_b),
        .empty   (empty_b),
        .drop    (drop_b)
    );

    assign idle    = (state == ST_IDLE);
    assign sel_b   = (state == ST_GNT_B);
    assign granted = (state == ST_GNT_A) || sel_b;
    assign busy    = !idle;
    assign len_eff = eff_len(len_pkg);

    assign elig_a = !empty_a && head_a.frm;
    assign elig_b = !empty_b && head_b.frm;
    // last_b set means B was served last (or fresh start): A has priority.
    assign gnt_a  = idle && elig_a && (!elig_b || last_b);
    assign gnt_b  = idle && elig_b && !gnt_a;

    assign sel_head  = sel_b ? head_b : head_a;
    assign sel_empty = sel_b ? empty_b : empty_a;

    // A frame start at the head of the granted FIFO ends the current frame.
    assign g_pop   = granted && !sel_empty && !sel_head.frm;
    assign g_trunc = granted && !sel_empty && sel_head.frm;
    assign g_tout  = granted && !g_pop && !g_trunc &&
                     (tout_cyc != '0) && ((tcnt + T_ONE) == tout_cyc);
    assign fin     = g_pop && (cnt == len_q - 16'd1);

    // The grant cycle also pops the frame start; idle heads without frm resync.
    assign pop_a = gnt_a || (idle && !empty_a && !head_a.frm) ||
                   (g_pop && !sel_b);
    assign pop_b = gnt_b || (idle && !empty_b && !head_b.frm) ||
                   (g_pop && sel_b);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            last_b    <= 1'b1;
            len_q     <= 16'd1;
            cnt       <= '0;
            tcnt      <= '0;
            pkg_data  <= '0;
            pkg_vld   <= 1'b0;
            pkg_frm   <= 1'b0;
            pkg_src   <= 1'b0;
            ovf_a     <= 1'b0;
            ovf_b     <= 1'b0;
            err_trunc <= 1'b0;
            err_tout  <= 1'b0;
        end else if (fire_sync) begin
            state     <= ST_IDLE;
            last_b    <= 1'b1;
            cnt       <= '0;
            tcnt      <= '0;
            pkg_vld   <= 1'b0;
            ovf_a     <= 1'b0;
            ovf_b     <= 1'b0;
            err_trunc <= 1'b0;
            err_tout  <= 1'b0;
        end else begin
            pkg_vld   <= 1'b0;
            err_trunc <= 1'b0;
            err_tout  <= 1'b0;
            ovf_a     <= ovf_a | drop_a;
            ovf_b     <= ovf_b | drop_b;
            unique case (state)
                ST_IDLE: begin
                    if (gnt_a || gnt_b) begin
                        pkg_vld  <= 1'b1;
                        pkg_frm  <= 1'b1;
                        pkg_src  <= gnt_b;
                        pkg_data <= gnt_b ? head_b.data : head_a.data;
                        len_q    <= len_eff;
                        cnt      <= 16'd1;
                        tcnt     <= '0;
                        if (len_eff == 16'd1) last_b <= gnt_b;
                        else state <= gnt_b ? ST_GNT_B : ST_GNT_A;
                    end
                end
                ST_GNT_A, ST_GNT_B: begin
                    unique case (1'b1)
                        g_trunc: begin
                            err_trunc <= 1'b1;
                            state     <= ST_IDLE;
                            last_b    <= sel_b;
                        end
                        g_pop: begin
                            pkg_vld  <= 1'b1;
                            pkg_frm  <= 1'b0;
                            pkg_src  <= sel_b;
                            pkg_data <= sel_head.data;
                            cnt      <= cnt + 16'd1;
                            tcnt     <= '0;
                            if (fin) begin
                                state  <= ST_IDLE;
                                last_b <= sel_b;
                            end
                        end
                        g_tout: begin
                            err_tout <= 1'b1;
                            state    <= ST_IDLE;
                            last_b   <= sel_b;
                        end
                        default: tcnt <= tcnt + T_ONE;
                    endcase
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_arb.sv
// tb_fetch_arb: directed stimulus, expected words queued in a scoreboard
// and popped by an independent output monitor.
module tb_fetch_arb;

    logic        clk_sys = 1'b0;
    logic        rst_n = 1'b0;
    logic        fire_sync = 1'b0;
    logic [15:0] pkga_data = '0;
    logic        pkga_vld = 1'b0;
    logic        pkga_frm = 1'b0;
    logic [15:0] pkgb_data = '0;
    logic        pkgb_vld = 1'b0;
    logic        pkgb_frm = 1'b0;
    logic [15:0] len_pkg = 16'd4;
    logic [19:0] tout_cyc = '0;
    logic [15:0] pkg_data;
    logic        pkg_vld, pkg_frm, pkg_src;
    logic        ovf_a, ovf_b, err_trunc, err_tout, busy;

    fetch_arb dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .fire_sync (fire_sync),
        .pkga_data (pkga_data),
        .pkga_vld  (pkga_vld),
        .pkga_frm  (pkga_frm),
        .pkgb_data (pkgb_data),
        .pkgb_vld  (pkgb_vld),
        .pkgb_frm  (pkgb_frm),
        .len_pkg   (len_pkg),
        .tout_cyc  (tout_cyc),
        .pkg_data  (pkg_data),
        .pkg_vld   (pkg_vld),
        .pkg_frm   (pkg_frm),
        .pkg_src   (pkg_src),
        .ovf_a     (ovf_a),
        .ovf_b     (ovf_b),
        .err_trunc (err_trunc),
        .err_tout  (err_tout),
        .busy      (busy)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        src;
        logic        frm;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_out = 0;
    int   last_out_cyc = 0;
    int   n_trunc = 0;
    int   trunc_out = 0;
    int   n_tout = 0;
    int   tout_seen_cyc = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Output monitor: every word presented must be the next expected one.
    always @(negedge clk_sys) begin
        if (rst_n && pkg_vld) begin
            n_out++;
            last_out_cyc = cyc;
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_word: got src=%0d frm=%0d data=%h, required none",
                         pkg_src, pkg_frm, pkg_data);
            end else begin
                e = sb.pop_front();
                if ({pkg_src, pkg_frm, pkg_data} !== {e.src, e.frm, e.data}) begin
                    n_fail++;
                    $display("FAIL word: got src=%0d frm=%0d data=%h, required src=%0d frm=%0d data=%h",
                             pkg_src, pkg_frm, pkg_data, e.src, e.frm, e.data);
                end
                if (e.cyc >= 0) begin
                    n_chk++;
                    if (cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL latency %h: got cycle %0d, required %0d",
                                 e.data, cyc, e.cyc);
                    end
                end
            end
        end
        if (rst_n && err_trunc) begin
            n_trunc++;
            trunc_out = n_out;
        end
        if (rst_n && err_tout) begin
            n_tout++;
            tout_seen_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic expect_w(input logic src, input logic frm,
                            input logic [15:0] d);
        sb.push_back('{src, frm, d, -1});
    endtask

    // One-cycle push on channel ch; exp queues the word, timed pins it to push+2.
    task automatic push(input logic ch, input logic [15:0] d, input logic f,
                        input bit exp, input bit timed);
        if (ch) begin
            pkgb_data = d; pkgb_frm = f; pkgb_vld = 1'b1;
        end else begin
            pkga_data = d; pkga_frm = f; pkga_vld = 1'b1;
        end
        if (exp) sb.push_back('{ch, f, d, timed ? cyc + 2 : -1});
        tick(1);
        pkga_vld = 1'b0; pkga_frm = 1'b0;
        pkgb_vld = 1'b0; pkgb_frm = 1'b0;
    endtask

    task automatic push_ab(input logic [15:0] da, input logic fa,
                           input logic [15:0] db, input logic fb);
        pkga_data = da; pkga_frm = fa; pkga_vld = 1'b1;
        pkgb_data = db; pkgb_frm = fb; pkgb_vld = 1'b1;
        tick(1);
        pkga_vld = 1'b0; pkga_frm = 1'b0;
        pkgb_vld = 1'b0; pkgb_frm = 1'b0;
    endtask

    task automatic fire();
        fire_sync = 1'b1;
        tick(1);
        fire_sync = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk("rst_pkg_vld", pkg_vld, 0);
        chk("rst_pkg_data", pkg_data, 0);
        chk("rst_pkg_frm_src", {pkg_frm, pkg_src}, 0);
        chk("rst_ovf", {ovf_a, ovf_b}, 0);
        chk("rst_err", {err_trunc, err_tout}, 0);
        chk("rst_busy", busy, 0);

        // Single frame on A, one word every 10 cycles.
        len_pkg = 16'd4;
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 16'h1000 + 16'(i), i == 0, 1'b1, 1'b1);
            tick(9);
        end
        chk("frame_a_busy_after", busy, 0);
        chk("frame_a_sb_empty", sb.size(), 0);

        // Simultaneous starts: A first after fire_sync, then round robin.
        fire();
        len_pkg = 16'd2;
        expect_w(1'b0, 1'b1, 16'hA000);
        expect_w(1'b0, 1'b0, 16'hA001);
        expect_w(1'b1, 1'b1, 16'hB000);
        expect_w(1'b1, 1'b0, 16'hB001);
        push_ab(16'hA000, 1'b1, 16'hB000, 1'b1);
        push_ab(16'hA001, 1'b0, 16'hB001, 1'b0);
        tick(8);
        chk("rr1_sb_empty", sb.size(), 0);
        push(1'b0, 16'hA010, 1'b1, 1'b1, 1'b0);
        push(1'b0, 16'hA011, 1'b0, 1'b1, 1'b0);
        tick(5);
        expect_w(1'b1, 1'b1, 16'hB020);
        expect_w(1'b1, 1'b0, 16'hB021);
        expect_w(1'b0, 1'b1, 16'hA020);
        expect_w(1'b0, 1'b0, 16'hA021);
        push_ab(16'hA020, 1'b1, 16'hB020, 1'b1);
        push_ab(16'hA021, 1'b0, 16'hB021, 1'b0);
        tick(8);
        chk("rr2_sb_empty", sb.size(), 0);

        // Overflow on A while B is granted and stalled.
        len_pkg = 16'd4;
        push(1'b1, 16'hB100, 1'b1, 1'b1, 1'b0);
        tick(2);
        for (int i = 0; i < 9; i++)
            push(1'b0, 16'hA100 + 16'(i), i == 0, 1'b0, 1'b0);
        chk("ovf_a_set", ovf_a, 1);
        chk("ovf_b_clear", ovf_b, 0);
        chk("busy_b_stalled", busy, 1);
        len_pkg = 16'd8;
        for (int i = 1; i < 4; i++)
            push(1'b1, 16'hB100 + 16'(i), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)
            expect_w(1'b0, i == 0, 16'hA100 + 16'(i));
        tick(20);
        chk("ovf_a_8_kept", sb.size(), 0);
        chk("ovf_a_sticky", ovf_a, 1);
        len_pkg = 16'd4;
        push(1'b1, 16'hB200, 1'b1, 1'b1, 1'b0);
        tick(2);
        push(1'b0, 16'hC000, 1'b1, 1'b0, 1'b0);
        fire_sync = 1'b1;
        pkga_data = 16'hC001; pkga_frm = 1'b1; pkga_vld = 1'b1;
        tick(1);
        fire_sync = 1'b0; pkga_vld = 1'b0; pkga_frm = 1'b0;
        tick(8);
        chk("fire_ovf_a", ovf_a, 0);
        chk("fire_busy", busy, 0);
        chk("fire_sb_empty", sb.size(), 0);

        // Truncated frame followed by a fresh one on A.
        base = n_out;
        push(1'b0, 16'hD000, 1'b1, 1'b1, 1'b0);
        tick(2);
        push(1'b0, 16'hD001, 1'b0, 1'b1, 1'b0);
        tick(2);
        push(1'b0, 16'hD002, 1'b1, 1'b1, 1'b0);
        tick(3);
        chk("trunc_count", n_trunc, 1);
        chk("trunc_after_words", trunc_out - base, 2);
        chk("trunc_regrant_busy", busy, 1);
        for (int i = 3; i < 6; i++)
            push(1'b0, 16'hD000 + 16'(i), 1'b0, 1'b1, 1'b0);
        tick(3);
        chk("trunc_next_done", busy, 0);
        chk("trunc_sb_empty", sb.size(), 0);

        // Inter-word timeout.
        tout_cyc = 20'd50;
        push(1'b0, 16'hE000, 1'b1, 1'b1, 1'b0);
        tick(2);
        push(1'b0, 16'hE001, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 200 && n_tout == 0; k++) tick(1);
        chk("tout_count", n_tout, 1);
        chk("tout_gap", tout_seen_cyc - last_out_cyc, 50);
        chk("tout_busy", busy, 0);
        tout_cyc = '0;

        // Orphan word discarded; zero length behaves as one word.
        push(1'b0, 16'h00AA, 1'b0, 1'b0, 1'b0);
        tick(5);
        chk("orphan_busy", busy, 0);
        len_pkg = 16'd0;
        push(1'b0, 16'h0055, 1'b1, 1'b1, 1'b0);
        tick(4);
        chk("len0_busy", busy, 0);
        chk("len0_sb_empty", sb.size(), 0);

        // Reset in mid-frame abandons the pending word.
        len_pkg = 16'd4;
        push(1'b0, 16'hF000, 1'b1, 1'b1, 1'b0);
        tick(3);
        push(1'b0, 16'hF001, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("midrst_vld", pkg_vld, 0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        chk("midrst_busy", busy, 0);
        chk("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_arb.md
FETCH_ARB -- requirements
Module: fetch_arb

Interface
REQ-001 Parameter FIFO_AW, default 3, log2 depth of each per-channel word FIFO (depth 8).
REQ-002 Parameter TOUT_W, default 20, width of the inter-word timeout counter.
REQ-003 clk_sys  input  1  system clock; the only clock, all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 fire_sync  input  1  acquisition-start pulse, 1 cycle, synchronous to clk_sys.
REQ-006 pkga_data / pkga_vld / pkga_frm  input  16/1/1  channel A package stream; frm high with the first word of a frame.
REQ-007 pkgb_data / pkgb_vld / pkgb_frm  input  16/1/1  channel B package stream, same semantics.
REQ-008 len_pkg  input  16  words per frame; quasi-static, sampled at grant.
REQ-009 tout_cyc  input  TOUT_W  maximum idle cycles between words of a granted frame.
REQ-010 pkg_data / pkg_vld / pkg_frm  output  16/1/1  merged stream; frm high with the first word of each frame.
REQ-011 pkg_src  output  1  source of the current pkg_vld word, 0=A, 1=B.
REQ-012 ovf_a / ovf_b  output  1 each  sticky FIFO-overflow flags.
REQ-013 err_trunc / err_tout  output  1 each  single-cycle error pulses.
REQ-014 busy  output  1  high when state is not IDLE.

Function
REQ-015 Each channel SHALL write {frm,data} into its own 17-bit FIFO on vld; no backpressure exists upstream.
REQ-016 A push to a full FIFO SHALL drop the word and set that channel's ovf flag; a same-cycle pop frees no room for it.
REQ-017 States SHALL be IDLE, GNT_A, GNT_B.
REQ-018 In IDLE, a FIFO whose head has frm=0 SHALL pop and discard that head, one word per cycle per channel (resync).
REQ-019 In IDLE, a channel is eligible when its head has frm=1; with one eligible, grant it; with both eligible, grant the one not granted last (round robin; after reset/fire_sync A wins).
REQ-020 On grant, the block SHALL latch len_pkg (0 treated as 1), clear the word counter and the timeout counter.
REQ-021 While granted with the FIFO non-empty and the head not a foreign frame start, one word SHALL pop per cycle; pkg_vld/pkg_data/pkg_frm/pkg_src SHALL be registered, valid the cycle after the pop.
REQ-022 Latency: word on pkgX_vld at cycle n with an empty FIFO and the channel granted SHALL appear on pkg_vld at n+2.
REQ-023 After the latched length is popped, state SHALL return to IDLE and record the granted channel as last.
REQ-024 If a granted FIFO head has frm=1 after the first word, the block SHALL pulse err_trunc, not pop, and return to IDLE (the new frame remains for arbitration).
REQ-025 Timeout counter SHALL increment each granted cycle without a pop and clear on each pop; on reaching tout_cyc, pulse err_tout and return to IDLE; tout_cyc=0 disables timeout.
REQ-026 fire_sync SHALL flush both FIFOs, force IDLE, clear ovf_a/ovf_b, reset round robin to favour A and suppress pkg_vld next cycle; it overrides same-cycle pushes (dropped, no ovf).
REQ-027 The non-granted FIFO SHALL continue accepting pushes during a grant.

Reset
REQ-028 On rst_n low: state IDLE, FIFOs empty, counters 0, pkg_data 0, pkg_vld 0, pkg_frm 0, pkg_src 0, ovf_a/ovf_b 0, err_trunc/err_tout 0, busy 0, round robin favours A.
REQ-029 Reset asserted mid-frame SHALL abandon the frame without emitting a further word.

Structure
REQ-030 State encodings and the 17-bit FIFO entry layout (bit 16 = frm) SHALL live in shared package fetch_arb_pkg.
REQ-031 The per-channel FIFO SHALL be one sub-module, fetch_arb_fifo (parameter FIFO_AW, flush input), instantiated twice.

Verification
REQ-032 len_pkg=4, A sends frame 0x1000..0x1003 spaced 10 cycles -> four pkg_vld words, frm on 0x1000, pkg_src=0, each at push+2.
REQ-033 A and B both push frame starts in the same cycle, len_pkg=2 -> A frame fully output, then B frame; repeat -> B first.
REQ-034 Nine pushes to A while B is granted and stalled -> ovf_a=1, eight A words retained; next fire_sync -> ovf_a=0, FIFOs empty.
REQ-035 len_pkg=4, A sends frm word plus 1 word then new frm word -> err_trunc pulse after 2 output words; new frame granted next.
REQ-036 tout_cyc=50, A sends 2 of 4 words then stops -> err_tout exactly 50 cycles after last pop, busy=0.
REQ-037 Push 0x00AA with frm=0 to idle A -> discarded, no pkg_vld.
